// File: rtl/mul_multicycle.sv
// Shift-add RV32M/RV64M multiplier, one multiplier bit per cycle: XLEN+1 cycles accept->out_valid (1 if an operand is zero).
// Result is held in DONE under arbitrary out_ready backpressure; in_ready only in IDLE, so no request overlaps a pending result.
module mul_multicycle #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_b,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      opcode,
  input  logic [XLEN-1:0] op1,
  input  logic [XLEN-1:0] op2,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN);
  localparam logic [CW-1:0] LAST_CNT = CW'(XLEN - 1);

  localparam logic [1:0] OP_MUL    = 2'b00;
  localparam logic [1:0] OP_MULH   = 2'b01;
  localparam logic [1:0] OP_MULHU  = 2'b11;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  typedef struct packed {
    logic [1:0] opc;
    logic       neg;
  } op_ctl_t;

  state_t            state;
  op_ctl_t           ctl;
  logic [XLEN-1:0]   mcand;
  logic [XLEN-1:0]   mplier;
  logic [2*XLEN-1:0] acc;
  logic [CW-1:0]     cnt;

  logic            op1_signed, op2_signed;
  logic            op1_neg, op2_neg;
  logic [XLEN-1:0] mag1, mag2;
  logic            any_zero;

  logic [XLEN:0]     sum;
  logic [XLEN:0]     upper;
  logic [2*XLEN-1:0] acc_shift;
  logic [2*XLEN-1:0] prod_final;

  // Operand conditioning for the accept cycle: sign flag and magnitudes.
  // The most negative value negates to itself, which is its correct unsigned magnitude.
  always_comb begin
    op1_signed = (opcode != OP_MULHU);
    op2_signed = (opcode == OP_MUL) || (opcode == OP_MULH);
    op1_neg    = op1_signed & op1[XLEN-1];
    op2_neg    = op2_signed & op2[XLEN-1];
    mag1       = op1_neg ? (~op1 + XLEN'(1)) : op1;
    mag2       = op2_neg ? (~op2 + XLEN'(1)) : op2;
    any_zero   = (op1 == '0) || (op2 == '0);
  end

  // One shift-add step: the carry out of the upper-half add becomes the new MSB.
  always_comb begin
    sum        = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, mcand};
    upper      = mplier[0] ? sum : {1'b0, acc[2*XLEN-1:XLEN]};
    acc_shift  = {upper, acc[XLEN-1:1]};
    prod_final = ctl.neg ? (~acc_shift + (2*XLEN)'(1)) : acc_shift;
  end

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      state  <= IDLE;
      ctl    <= '0;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
      result <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            ctl.opc <= opcode;
            ctl.neg <= op1_neg ^ op2_neg;
            mcand   <= mag1;
            mplier  <= mag2;
            acc     <= '0;
            cnt     <= '0;
            if (any_zero) begin
              result <= '0;
              state  <= DONE;
            end else begin
              state  <= BUSY;
            end
          end
        end
        BUSY: begin
          acc    <= acc_shift;
          mplier <= mplier >> 1;
          cnt    <= cnt + CW'(1);
          if (cnt == LAST_CNT) begin
            result <= (ctl.opc == OP_MUL) ? prod_final[XLEN-1:0]
                                          : prod_final[2*XLEN-1:XLEN];
            state  <= DONE;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

endmodule
